// File: rtl/cpu_defs.sv
// Shared definitions for the 16-bit pipelined CPU: widths, reset PC, bubble opcode.
// Latency: none; this package holds constants and types only.
// Backpressure: none; imported by fetch, instruction memory, decode and pipe registers.
package cpu_defs;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam instr_t NOP_INSTR = 16'h0800;
  localparam addr_t  RESET_PC  = 16'h0000;

  // Sequential successor of a PC; wraps modulo 2^16.
  function automatic addr_t pc_next(input addr_t pc);
    return pc + 16'd1;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds the fetched instruction, its PC+1 and a valid flag.
// Latency: one cycle from load to outputs; outputs come straight from flops.
// Backpressure: with neither load nor bubble asserted the register holds (stall).
module if_id_reg
  import cpu_defs::*;
#(
  parameter instr_t BUBBLE_INSTR = cpu_defs::NOP_INSTR
) (
  input  logic   CLK,
  input  logic   RST,
  input  logic   load,
  input  logic   bubble,
  input  addr_t  pc_in,
  input  instr_t instr_in,
  output addr_t  id_pc,
  output instr_t id_instr,
  output logic   id_valid
);

  // Reset > load > bubble > hold; a bubble clears the instruction but keeps the branch base.
  always_ff @(posedge CLK) begin
    if (RST) begin
      id_pc    <= '0;
      id_instr <= BUBBLE_INSTR;
      id_valid <= 1'b0;
    end else if (load) begin
      id_pc    <= pc_in;
      id_instr <= instr_in;
      id_valid <= 1'b1;
    end else if (bubble) begin
      id_instr <= BUBBLE_INSTR;
      id_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch: owns the PC, paces each SRAM access over MEM_LAT cycles, fills IF/ID.
// Latency: first valid instruction MEM_LAT cycles after reset release; one per MEM_LAT cycles.
// Backpressure: stall_i freezes PC, phase and IF/ID; redirect_i overrides stall and aborts the fetch.
module instr_fetch_stage #(
  parameter logic [cpu_defs::ADDR_W-1:0]  RESET_PC  = cpu_defs::RESET_PC,
  parameter int                           MEM_LAT   = 2,
  parameter logic [cpu_defs::INSTR_W-1:0] NOP_INSTR = cpu_defs::NOP_INSTR
) (
  input  logic                           CLK,
  input  logic                           RST,
  output logic [cpu_defs::ADDR_W-1:0]    mem_addr,
  input  logic [cpu_defs::INSTR_W-1:0]   mem_instr,
  input  logic                           stall_i,
  input  logic                           redirect_i,
  input  logic [cpu_defs::ADDR_W-1:0]    redirect_pc_i,
  output logic [cpu_defs::ADDR_W-1:0]    id_pc_o,
  output logic [cpu_defs::INSTR_W-1:0]   id_instr_o,
  output logic                           id_valid_o
);

  import cpu_defs::*;

  // Phase index of the edge on which the memory word is valid (MEM_LAT is 1..4).
  localparam logic [1:0] LAST_PHASE = 2'(MEM_LAT - 1);

  addr_t      pc;
  logic [1:0] phase;
  logic       fetch_done;
  logic       if_load;
  logic       if_bubble;

  assign fetch_done = (phase == LAST_PHASE);
  assign mem_addr   = pc;

  // IF/ID control: redirect squashes, stall holds, otherwise capture on the last phase.
  always_comb begin
    if_load   = 1'b0;
    if_bubble = 1'b0;
    if (redirect_i) begin
      if_bubble = 1'b1;
    end else if (!stall_i) begin
      if (fetch_done) begin
        if_load = 1'b1;
      end else begin
        if_bubble = 1'b1;
      end
    end
  end

  // PC and access phase; an aborted or reset fetch simply restarts at phase 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc    <= RESET_PC;
      phase <= 2'd0;
    end else if (redirect_i) begin
      pc    <= redirect_pc_i;
      phase <= 2'd0;
    end else if (!stall_i) begin
      if (fetch_done) begin
        pc    <= pc_next(pc);
        phase <= 2'd0;
      end else begin
        phase <= phase + 2'd1;
      end
    end
  end

  if_id_reg #(
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_if_id (
    .CLK      (CLK),
    .RST      (RST),
    .load     (if_load),
    .bubble   (if_bubble),
    .pc_in    (pc_next(pc)),
    .instr_in (mem_instr),
    .id_pc    (id_pc_o),
    .id_instr (id_instr_o),
    .id_valid (id_valid_o)
  );

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: three instances (MEM_LAT=2, wrap-around reset PC, MEM_LAT=1)
// share stall/redirect/reset stimulus; each has a memory model (addr ^ 0x1234) and a
// reference model built from the fetch rules, plus directed checks of the documented sequences.
module tb_instr_fetch_stage;

  localparam logic [15:0] NOP = 16'h0800;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic        stall_i;
  logic        redirect_i;
  logic [15:0] redirect_pc_i;

  logic [15:0] a_addr, a_mem, a_pc, a_instr;
  logic        a_v;
  logic [15:0] b_addr, b_mem, b_pc, b_instr;
  logic        b_v;
  logic [15:0] c_addr, c_mem, c_pc, c_instr;
  logic        c_v;

  assign a_mem = a_addr ^ 16'h1234;
  assign b_mem = b_addr ^ 16'h1234;
  assign c_mem = c_addr ^ 16'h1234;

  instr_fetch_stage #(.RESET_PC(16'h0000), .MEM_LAT(2), .NOP_INSTR(NOP)) dut_a (
    .CLK(CLK), .RST(RST), .mem_addr(a_addr), .mem_instr(a_mem), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .id_pc_o(a_pc), .id_instr_o(a_instr), .id_valid_o(a_v));

  instr_fetch_stage #(.RESET_PC(16'hFFFF), .MEM_LAT(2), .NOP_INSTR(NOP)) dut_b (
    .CLK(CLK), .RST(RST), .mem_addr(b_addr), .mem_instr(b_mem), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .id_pc_o(b_pc), .id_instr_o(b_instr), .id_valid_o(b_v));

  instr_fetch_stage #(.RESET_PC(16'h0000), .MEM_LAT(1), .NOP_INSTR(NOP)) dut_c (
    .CLK(CLK), .RST(RST), .mem_addr(c_addr), .mem_instr(c_mem), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .id_pc_o(c_pc), .id_instr_o(c_instr), .id_valid_o(c_v));

  // Reference: address being fetched, cycles already spent on it, and the IF/ID contents.
  typedef struct {
    logic [15:0] pc;
    int          waited;
    logic [15:0] id_pc;
    logic [15:0] id_instr;
    logic        id_valid;
  } mstate_t;

  mstate_t ma, mb, mc;
  int checks = 0;
  int errors = 0;

  function automatic mstate_t mstep(input mstate_t m, input int lat, input logic [15:0] rst_pc,
                                    input logic rst, input logic stall, input logic redir,
                                    input logic [15:0] rpc);
    mstate_t n = m;
    if (rst) begin
      n.pc = rst_pc; n.waited = 0; n.id_pc = 16'h0000; n.id_instr = NOP; n.id_valid = 1'b0;
    end else if (redir) begin
      n.pc = rpc; n.waited = 0; n.id_instr = NOP; n.id_valid = 1'b0;
    end else if (!stall) begin
      if (m.waited + 1 == lat) begin
        n.id_instr = m.pc ^ 16'h1234;
        n.id_pc    = m.pc + 16'd1;
        n.id_valid = 1'b1;
        n.pc       = m.pc + 16'd1;
        n.waited   = 0;
      end else begin
        n.waited   = m.waited + 1;
        n.id_instr = NOP;
        n.id_valid = 1'b0;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmp(input string n, input mstate_t m, input logic [15:0] addr,
                     input logic [15:0] idpc, input logic [15:0] instr, input logic v);
    check({n, "_mem_addr"}, addr, m.pc);
    check({n, "_id_pc"}, idpc, m.id_pc);
    check({n, "_id_instr"}, instr, m.id_instr);
    check({n, "_id_valid"}, {15'b0, v}, {15'b0, m.id_valid});
  endtask

  // One clock: advance the models at the edge, compare everything on the falling edge.
  task automatic step();
    @(posedge CLK);
    ma = mstep(ma, 2, 16'h0000, RST, stall_i, redirect_i, redirect_pc_i);
    mb = mstep(mb, 2, 16'hFFFF, RST, stall_i, redirect_i, redirect_pc_i);
    mc = mstep(mc, 1, 16'h0000, RST, stall_i, redirect_i, redirect_pc_i);
    @(negedge CLK);
    cmp("a", ma, a_addr, a_pc, a_instr, a_v);
    cmp("b", mb, b_addr, b_pc, b_instr, b_v);
    cmp("c", mc, c_addr, c_pc, c_instr, c_v);
  endtask

  initial begin
    RST = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 16'h0000;
    ma = '{pc: 16'h0, waited: 0, id_pc: 16'h0, id_instr: NOP, id_valid: 1'b0};
    mb = ma;
    mc = ma;

    // Reset state
    step(); step();
    check("rst_a_instr", a_instr, NOP);
    check("rst_b_addr", b_addr, 16'hFFFF);
    check("rst_a_valid", {15'b0, a_v}, 16'd0);
    RST = 1'b0;

    // Free run: one instruction per two cycles on a, every cycle on c, wrap on b
    for (int k = 1; k <= 6; k++) begin
      step();
      check("t1_addr", a_addr, 16'(k / 2));
      check("t1_valid", {15'b0, a_v}, (k % 2 == 0) ? 16'd1 : 16'd0);
      if (k % 2 == 0) begin
        check("t1_instr", a_instr, 16'h1234 + 16'(k / 2 - 1));
        check("t1_idpc", a_pc, 16'(k / 2));
      end else begin
        check("t1_bubble", a_instr, NOP);
      end
      check("t6_c_addr", c_addr, 16'(k));
      check("t6_c_valid", {15'b0, c_v}, 16'd1);
      if (k == 2) begin
        check("t5_b_instr", b_instr, 16'hEDCB);
        check("t5_b_idpc", b_pc, 16'h0000);
        check("t5_b_addr", b_addr, 16'h0000);
      end
    end

    // Stall for three cycles at phase 1 of address 3
    step();
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t2_hold_addr", a_addr, 16'h0003);
      check("t2_hold_valid", {15'b0, a_v}, 16'd0);
    end
    stall_i = 1'b0;
    step();
    check("t2_instr", a_instr, 16'h1237);
    check("t2_idpc", a_pc, 16'h0004);
    check("t2_valid", {15'b0, a_v}, 16'd1);
    step();
    check("t2_once", {15'b0, a_v}, 16'd0);

    // Redirect at phase 1 of address 5
    step(); step();
    redirect_i = 1'b1; redirect_pc_i = 16'h0040;
    step();
    redirect_i = 1'b0;
    check("t3_addr", a_addr, 16'h0040);
    check("t3_valid", {15'b0, a_v}, 16'd0);
    check("t3_instr", a_instr, NOP);
    step(); step();
    check("t3_dlv_instr", a_instr, 16'h1274);
    check("t3_dlv_idpc", a_pc, 16'h0041);

    // Redirect together with stall
    redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 16'h0100;
    step();
    redirect_i = 1'b0; stall_i = 1'b0;
    check("t4_addr", a_addr, 16'h0100);
    check("t4_valid", {15'b0, a_v}, 16'd0);
    check("t4_instr", a_instr, NOP);

    // Reset mid-fetch at phase 1 of address 7
    redirect_i = 1'b1; redirect_pc_i = 16'h0007;
    step();
    redirect_i = 1'b0;
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("t6_rst_addr", a_addr, 16'h0000);
    check("t6_rst_idpc", a_pc, 16'h0000);
    check("t6_rst_instr", a_instr, NOP);
    check("t6_rst_valid", {15'b0, a_v}, 16'd0);
    step(); step();
    check("t6_first_instr", a_instr, 16'h1234);

    // Randomized traffic against the models
    for (int k = 0; k < 500; k++) begin
      RST           = ($urandom_range(0, 49) == 0);
      stall_i       = ($urandom_range(0, 3) == 0);
      redirect_i    = ($urandom_range(0, 7) == 0);
      redirect_pc_i = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Upstream neighbour of the instruction memory in the 16-bit pipelined CPU.
- Owns the program counter and drives the fetch address to the instruction memory.
- Paces each fetch to the memory's fixed multi-cycle SRAM access and captures the returned word into the IF/ID pipeline register for decode.
- Handles pipeline stall and branch/jump redirect from ID.

Parameters:
- RESET_PC, 16'h0000: PC value after reset.
- MEM_LAT, 2: cycles the fetch address is held per access. Legal values are 1..4.
- NOP_INSTR, 16'h0800: bubble instruction written into IF/ID.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous reset, active-high.
- mem_addr  output  16  fetch address to instruction memory; driven directly from the PC register.
- mem_instr  input  16  instruction word returned by memory; valid at the rising edge ending phase MEM_LAT-1.
- stall_i  input  1  hazard stall from ID; freezes the stage.
- redirect_i  input  1  branch taken / jump from ID.
- redirect_pc_i  input  16  new PC when redirect_i=1.
- id_pc_o  output  16  PC+1 of the delivered instruction (branch base).
- id_instr_o  output  16  IF/ID instruction.
- id_valid_o  output  1  IF/ID holds a real fetched instruction.

Behaviour:
- State:
  - pc[15:0].
  - phase counter 0..MEM_LAT-1.
  - IF/ID registers: id_pc, id_instr, id_valid.
- Reset (RST=1 at an edge), values after that edge:
  - pc=RESET_PC, so mem_addr=RESET_PC.
  - phase=0.
  - id_instr=NOP_INSTR, id_pc=0x0000, id_valid=0.
  - A fetch in progress when reset is asserted is discarded.
- Edge priority: RST > redirect_i > stall_i > normal.
- Normal operation, phase < MEM_LAT-1:
  - phase increments; pc unchanged.
  - IF/ID loads id_instr=NOP_INSTR, id_valid=0; id_pc holds.
- Normal operation, phase = MEM_LAT-1 (fetch completes at this edge):
  - id_instr<=mem_instr, id_pc<=pc+1, id_valid<=1.
  - pc<=pc+1, phase<=0.
- Throughput: one instruction per MEM_LAT cycles. id_valid_o is a one-cycle pulse per instruction unless a stall freezes it.
- Latency: first id_valid_o=1 appears MEM_LAT cycles after reset deasserts.
- Stall (stall_i=1, no redirect):
  - pc, phase, id_pc, id_instr and id_valid all hold; mem_addr stays stable.
  - At phase MEM_LAT-1 the word is not captured; the memory re-reads the same address until the stall releases.
  - The held instruction is delivered exactly once after the stall releases.
- Redirect (redirect_i=1):
  - pc<=redirect_pc_i, phase<=0.
  - id_instr<=NOP_INSTR, id_valid<=0, id_pc holds.
  - Any in-progress fetch is aborted, even at phase MEM_LAT-1.
  - Redirect wins over a simultaneous stall_i.
- Arithmetic: pc+1 is modulo 2^16, so 0xFFFF wraps to 0x0000 for both pc and id_pc.
- redirect_pc_i is used as given; no alignment check.
- No combinational path from any input to any output.

Decomposition:
- Shared package cpu_defs:
  - INSTR_W=16, ADDR_W=16.
  - NOP_INSTR=16'h0800, RESET_PC.
  - Also imported by the instruction memory, decode and other pipeline registers.
- One natural sub-module, if_id_reg, holding id_pc/id_instr/id_valid with load, bubble, hold and reset controls.
- PC and phase logic stay in the top module.

Test Plan (memory model returns mem_instr = mem_addr ^ 16'h1234, MEM_LAT=2 unless stated):
1. Release RST, free run -> mem_addr 0,0,1,1,2,2. id_valid_o pulses on cycles 2,4,6 with id_instr 0x1234,0x1235,0x1236 and id_pc 1,2,3. id_instr=0x0800 between pulses.
2. stall_i=1 for 3 cycles starting at phase 1 of addr 3 -> mem_addr stays 3, outputs frozen, no capture. First edge after release delivers 0x1237 with id_pc 4, exactly once.
3. redirect_i=1, redirect_pc_i=0x0040 at phase 1 of addr 5 -> addr 5 never delivered. Next cycle: mem_addr=0x0040, id_valid_o=0, id_instr=0x0800. Two cycles later: 0x1274 delivered with id_pc 0x0041.
4. redirect_i and stall_i both 1, target 0x0100 -> redirect taken: mem_addr=0x0100 next cycle, bubble in IF/ID.
5. RESET_PC=0xFFFF -> first delivery id_instr=0xEDCB, id_pc=0x0000; mem_addr then wraps to 0x0000.
6. RST=1 for one edge at phase 1 of addr 7, and MEM_LAT=1 run -> after the reset edge all outputs at reset values, addr 7 not delivered. MEM_LAT=1: id_valid_o=1 every cycle, mem_addr increments every cycle.
